// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
// Shared constants and types for the snake game grid renderer:
//   - cell codes stored in the grid map
//   - grid geometry (40 x 30 cells) and display limits (640 x 480)
//   - controller FSM state encoding
//   - cell_addr(): row*40+col computed with shifts and adds only
// -----------------------------------------------------------------------------
package snake_pkg;

    localparam int GRID_W = 40;
    localparam int GRID_H = 30;
    localparam int CELLS  = GRID_W * GRID_H;
    localparam int ADDR_W = 11;

    localparam logic [9:0]        DISP_W    = 10'd640;
    localparam logic [9:0]        DISP_H    = 10'd480;
    localparam logic [ADDR_W-1:0] CELL_LAST = 11'd1199;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_SNAKE = 2'b01,
        CELL_APPLE = 2'b10,
        CELL_WALL  = 2'b11
    } cell_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // row*40 + col as (row<<5) + (row<<3) + col
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ADDR_W-1:0] col,
                                                    input logic [ADDR_W-1:0] row);
        return (row << 5) + (row << 3) + col;
    endfunction

endpackage

// File: rtl/grid_ram.sv
// -----------------------------------------------------------------------------
// grid_ram
// Simple dual-port 1200 x 2-bit map RAM: one synchronous write port and one
// registered read port. A read and a write to the same address in the same
// cycle return the old contents. The array has no reset.
//   clk_i     : clock
//   we_i      : write enable
//   waddr_i   : write address
//   wdata_i   : write data (cell code)
//   raddr_i   : read address
//   rdata_o   : registered read data
// -----------------------------------------------------------------------------
module grid_ram
    import snake_pkg::*;
(
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [1:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [1:0]        rdata_o
);

    logic [1:0] mem_q [CELLS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/game_grid_renderer.sv
// -----------------------------------------------------------------------------
// game_grid_renderer
// Holds the 40x30 game map and turns the VGA pixel position into the cell code
// under that pixel, two clocks later. Cell writes are only taken during
// vertical blank; a clear request sweeps all 1200 cells to empty, one per
// cycle, while rendering carries on. Reset release starts such a sweep.
//   clock_25    : 25 MHz pixel clock
//   reset       : synchronous, active-high
//   X, Y        : current pixel column/row from the timing stage
//   wr_valid    : cell write request        wr_ready : write may complete
//   wr_col/row  : target cell               wr_data  : cell code
//   clear_req   : one-cycle clear request   clear_busy : sweep running
//   game_data   : cell code at the pixel    game_enable : display area flag
//   frame_tick  : one-cycle pulse at the start of vertical blank
// -----------------------------------------------------------------------------
module game_grid_renderer #(
    parameter int GRID_W     = 40,
    parameter int GRID_H     = 30,
    parameter int CELL_SHIFT = 4
) (
    input  logic       clock_25,
    input  logic       reset,
    input  logic [9:0] X,
    input  logic [9:0] Y,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [5:0] wr_col,
    input  logic [4:0] wr_row,
    input  logic [1:0] wr_data,
    input  logic       clear_req,
    output logic       clear_busy,
    output logic [1:0] game_data,
    output logic       game_enable,
    output logic       frame_tick
);

    import snake_pkg::*;

    localparam logic [5:0] COL_LIM = 6'(GRID_W);
    localparam logic [4:0] ROW_LIM = 5'(GRID_H);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic              y480_q;

    logic [9:0]        x_cell, y_cell;
    logic              vblank, disp_en;
    logic [ADDR_W-1:0] rd_addr_d, rd_addr_p1_q;
    logic              en_p1_q, en_p2_q;
    logic [1:0]        rdata_p2;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [1:0]        ram_wdata;
    logic              wr_in_range;

    assign vblank  = (Y >= DISP_H);
    assign disp_en = (X < DISP_W) && (Y < DISP_H);
    assign x_cell  = X >> CELL_SHIFT;
    assign y_cell  = Y >> CELL_SHIFT;

    // Outside the display the cell index can exceed the map, so park on 0;
    // the data is masked by the delayed enable anyway.
    assign rd_addr_d = disp_en ? cell_addr({1'b0, x_cell}, {1'b0, y_cell}) : '0;

    assign wr_in_range = (wr_col < COL_LIM) && (wr_row < ROW_LIM);

    // wr_ready drops in a cycle carrying clear_req so that a coincident write
    // is visibly refused rather than silently wiped by the sweep.
    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        ram_we     = 1'b0;
        ram_waddr  = sweep_q;
        ram_wdata  = CELL_EMPTY;
        wr_ready   = (state_q == ST_IDLE) && vblank && !clear_req && !reset;
        clear_busy = (state_q == ST_CLEAR);
        frame_tick = (Y == DISP_H) && !y480_q && !reset;

        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    sweep_d = '0;
                end else if (wr_valid && wr_ready && wr_in_range) begin
                    ram_we    = 1'b1;
                    ram_waddr = cell_addr({5'b0, wr_col}, {6'b0, wr_row});
                    ram_wdata = wr_data;
                end
            end
            ST_CLEAR: begin
                ram_we = 1'b1;
                if (sweep_q == CELL_LAST) begin
                    state_d = ST_IDLE;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + 11'd1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                sweep_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            sweep_q <= '0;
            y480_q  <= 1'b0;
            en_p1_q <= 1'b0;
            en_p2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            y480_q  <= (Y == DISP_H);
            en_p1_q <= disp_en;
            en_p2_q <= en_p1_q;
        end
    end

    // stage p1: registered read address
    always_ff @(posedge clock_25) begin
        rd_addr_p1_q <= rd_addr_d;
    end

    // stage p2: RAM read register
    grid_ram u_grid_ram (
        .clk_i   (clock_25),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (rd_addr_p1_q),
        .rdata_o (rdata_p2)
    );

    assign game_enable = en_p2_q;
    assign game_data   = en_p2_q ? rdata_p2 : CELL_EMPTY;

endmodule

// File: tb/tb_game_grid_renderer.sv
module tb_game_grid_renderer;

    logic       clock_25 = 1'b0;
    logic       reset    = 1'b1;
    logic [9:0] X        = '0;
    logic [9:0] Y        = '0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [5:0] wr_col   = '0;
    logic [4:0] wr_row   = '0;
    logic [1:0] wr_data  = '0;
    logic       clear_req = 1'b0;
    logic       clear_busy;
    logic [1:0] game_data;
    logic       game_enable;
    logic       frame_tick;

    int tests = 0;
    int fails = 0;

    // reference map, indexed row*40+col
    logic [1:0] model [1200];
    int px[$];
    int py[$];

    always #20 clock_25 = ~clock_25;

    game_grid_renderer #(.GRID_W(40), .GRID_H(30), .CELL_SHIFT(4)) dut (
        .clock_25    (clock_25),
        .reset       (reset),
        .X           (X),
        .Y           (Y),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_col      (wr_col),
        .wr_row      (wr_row),
        .wr_data     (wr_data),
        .clear_req   (clear_req),
        .clear_busy  (clear_busy),
        .game_data   (game_data),
        .game_enable (game_enable),
        .frame_tick  (frame_tick)
    );

    task automatic step();
        @(posedge clock_25);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_en(input int x, input int y);
        return (x < 640) && (y < 480);
    endfunction

    function automatic logic [1:0] exp_pix(input int x, input int y);
        if (!exp_en(x, y)) return 2'b00;
        return model[(y / 16) * 40 + (x / 16)];
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 1200; i++) model[i] = 2'b00;
    endfunction

    // Streams the queued pixels one per cycle; each result is due two edges
    // after its pixel was driven.
    task automatic run_scan(input string tag);
        logic [1:0] qd[$];
        logic       qe[$];
        for (int i = 0; i < px.size(); i++) begin
            X = 10'(px[i]);
            Y = 10'(py[i]);
            qd.push_back(exp_pix(px[i], py[i]));
            qe.push_back(exp_en(px[i], py[i]));
            step();
            if (qd.size() == 2) begin
                chk({tag, "_data"}, 32'(game_data), 32'(qd.pop_front()));
                chk({tag, "_en"}, 32'(game_enable), 32'(qe.pop_front()));
            end
        end
        X = 10'd1023;
        Y = 10'd1023;
        step();
        while (qd.size() > 0) begin
            chk({tag, "_data"}, 32'(game_data), 32'(qd.pop_front()));
            chk({tag, "_en"}, 32'(game_enable), 32'(qe.pop_front()));
        end
        px.delete();
        py.delete();
    endtask

    task automatic add_pix(input int x, input int y);
        px.push_back(x);
        py.push_back(y);
    endtask

    task automatic scan_all_cells(input string tag);
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 40; c++)
                add_pix(c * 16 + int'($urandom_range(15)), r * 16 + int'($urandom_range(15)));
        run_scan(tag);
    endtask

    task automatic do_write(input int col, input int row, input int data, input string tag);
        X        = 10'd0;
        Y        = 10'd500;
        wr_valid = 1'b1;
        wr_col   = 6'(col);
        wr_row   = 5'(row);
        wr_data  = 2'(data);
        #1;
        chk(tag, 32'(wr_ready), 32'd1);
        step();
        wr_valid = 1'b0;
        if (col < 40 && row < 30) model[row * 40 + col] = 2'(data);
    endtask

    initial begin
        int cnt;
        int bad;

        // reset and power-up sweep
        reset = 1'b1;
        X = 10'd0;
        Y = 10'd480;
        step();
        chk("rst_game_data", 32'(game_data), 32'd0);
        chk("rst_game_enable", 32'(game_enable), 32'd0);
        chk("rst_frame_tick", 32'(frame_tick), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_clear_busy", 32'(clear_busy), 32'd1);
        reset = 1'b0;
        cnt = 0;
        bad = 0;
        while (clear_busy === 1'b1 && cnt < 3000) begin
            if (wr_ready !== 1'b0) bad++;
            cnt++;
            step();
        end
        chk("init_sweep_len", 32'(cnt), 32'd1200);
        chk("init_sweep_wr_ready", 32'(bad), 32'd0);
        model_clear();
        scan_all_cells("init_all_empty");

        // single apple at (3,2), scan around it
        do_write(3, 2, 2, "apple_wr_ready");
        for (int y = 28; y < 52; y++)
            for (int x = 40; x < 72; x++)
                add_pix(x, y);
        run_scan("apple_scan");

        // out-of-range writes complete but leave the map alone
        do_write(40, 0, 3, "oor_col_ready");
        do_write(0, 30, 1, "oor_row_ready");
        add_pix(0, 0);
        add_pix(15, 16);
        add_pix(16, 0);
        add_pix(5, 470);
        run_scan("oor_scan");

        // held write outside vblank, completes on entry to vblank
        X = 10'd0;
        Y = 10'd100;
        wr_valid = 1'b1;
        wr_col = 6'd6;
        wr_row = 5'd6;
        wr_data = 2'd3;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("active_wr_ready", 32'(wr_ready), 32'd0);
            chk("active_frame_tick", 32'(frame_tick), 32'd0);
            step();
        end
        wr_col = 6'd5;
        wr_row = 5'd5;
        wr_data = 2'd1;
        Y = 10'd480;
        #1;
        chk("vb_wr_ready", 32'(wr_ready), 32'd1);
        chk("vb_frame_tick", 32'(frame_tick), 32'd1);
        step();
        wr_valid = 1'b0;
        model[5 * 40 + 5] = 2'd1;
        chk("vb_frame_tick_once", 32'(frame_tick), 32'd0);
        step();
        chk("vb_frame_tick_held", 32'(frame_tick), 32'd0);
        add_pix(80, 80);
        add_pix(96, 96);
        add_pix(79, 80);
        run_scan("held_wr_scan");

        // display-area boundaries
        do_write(39, 29, 3, "edge_wr0");
        do_write(0, 1, 3, "edge_wr1");
        do_write(39, 0, 1, "edge_wr2");
        do_write(0, 29, 2, "edge_wr3");
        add_pix(639, 479);
        add_pix(640, 479);
        add_pix(639, 480);
        add_pix(640, 0);
        add_pix(0, 480);
        add_pix(640, 480);
        add_pix(639, 0);
        add_pix(0, 479);
        run_scan("edge_scan");

        // random writes (some out of range) and random pixels
        for (int i = 0; i < 40; i++)
            do_write(int'($urandom_range(47)), int'($urandom_range(31)),
                     int'($urandom_range(3)), "rand_wr_ready");
        for (int i = 0; i < 400; i++)
            add_pix(int'($urandom_range(700)), int'($urandom_range(520)));
        run_scan("rand_scan");

        // clear beats a coincident write; second clear mid-sweep is ignored
        do_write(3, 2, 2, "pre_clear_wr");
        X = 10'd0;
        Y = 10'd500;
        clear_req = 1'b1;
        wr_valid = 1'b1;
        wr_col = 6'd1;
        wr_row = 5'd1;
        wr_data = 2'd2;
        #1;
        chk("clr_wr_refused", 32'(wr_ready), 32'd0);
        step();
        clear_req = 1'b0;
        wr_valid = 1'b0;
        chk("clr_busy", 32'(clear_busy), 32'd1);
        cnt = 0;
        for (int j = 0; j < 500; j++) begin
            // cell (3,2) is address 83: the read issued at sweep 82 meets the
            // sweep write of 83 and must see the old value
            if (j == 84) begin
                chk("collide_old_data", 32'(game_data), 32'd2);
                chk("collide_old_en", 32'(game_enable), 32'd1);
            end
            if (j == 85) chk("collide_new_data", 32'(game_data), 32'd0);
            if (j == 82 || j == 83) begin
                X = 10'd48;
                Y = 10'd32;
            end else begin
                X = 10'd0;
                Y = 10'd500;
            end
            if (clear_busy === 1'b1) cnt++;
            step();
        end
        clear_req = 1'b1;
        while (clear_busy === 1'b1 && cnt < 3000) begin
            cnt++;
            step();
            clear_req = 1'b0;
        end
        clear_req = 1'b0;
        chk("clr_no_restart_len", 32'(cnt), 32'd1200);
        model_clear();
        scan_all_cells("after_clear_empty");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/game_grid_renderer.md
GAME_GRID_RENDERER -- requirements
Module: game_grid_renderer

Interface
REQ-001 SHALL have parameter GRID_W, default 40, meaning grid columns.
REQ-002 SHALL have parameter GRID_H, default 30, meaning grid rows.
REQ-003 SHALL have parameter CELL_SHIFT, default 4, meaning log2 of the cell size in pixels (16x16 cells).
REQ-004 SHALL have port clock_25 input 1: the single clock (25 MHz pixel clock); all logic is on its rising edge.
REQ-005 SHALL have port reset input 1: reset, synchronous, active-high.
REQ-006 SHALL have port X input 10: current pixel column from the VGA timing stage.
REQ-007 SHALL have port Y input 10: current pixel row from the VGA timing stage.
REQ-008 SHALL have ports wr_valid input 1 and wr_ready output 1: cell-write handshake.
REQ-009 SHALL have ports wr_col input 6, wr_row input 5 and wr_data input 2: target cell and its cell code.
REQ-010 SHALL have port clear_req input 1: one-cycle request to clear the grid.
REQ-011 SHALL have port clear_busy output 1: high while a clear sweep runs.
REQ-012 SHALL have port game_data output 2: cell code at the pixel, to the VGA stage.
REQ-013 SHALL have port game_enable output 1: game_data valid (display area), to the VGA stage.
REQ-014 SHALL have port frame_tick output 1: one-cycle pulse at vertical-blank start.

Function
REQ-015 SHALL use the cell codes 00 empty, 01 snake, 10 apple, 11 wall.
REQ-016 SHALL store a GRID_W*GRID_H x 2-bit map, with address = row*40+col computed by shift-add (row<<5 + row<<3 + col), no divider or multiplier.
REQ-017 SHALL form the read cell as col = X>>CELL_SHIFT, row = Y>>CELL_SHIFT.
REQ-018 SHALL produce read latency of exactly 2 cycles: address registered at cycle n, RAM read at n+1, game_data registered at n+2.
REQ-019 SHALL make game_enable equal (X<640 && Y<480), delayed by the same 2 cycles.
REQ-020 SHALL force game_data to 00 whenever the delayed game_enable is 0.
REQ-021 SHALL define vblank as Y>=480.
REQ-022 SHALL assert frame_tick for one cycle on the first cycle Y==480 (previous Y!=480).
REQ-023 SHALL use FSM states IDLE and CLEAR.
REQ-024 SHALL hold wr_ready = (state==IDLE) && vblank.
REQ-025 SHALL commit a write when wr_valid && wr_ready, taking effect 1 cycle later.
REQ-026 SHALL accept and silently discard writes with wr_col>=40 or wr_row>=30 (handshake completes, map unchanged).
REQ-027 SHALL resolve a same-cycle read and write to the same address by returning the old data.
REQ-028 SHALL move IDLE->CLEAR on clear_req, regardless of vblank.
REQ-029 SHALL, in CLEAR, write 00 at sweep addresses 0..1199, one per cycle; after address 1199 it returns to IDLE, taking 1200 cycles total.
REQ-030 SHALL hold clear_busy = (state==CLEAR).
REQ-031 SHALL ignore clear_req during CLEAR (no restart).
REQ-032 SHALL give clear_req priority over a coincident wr_valid: the write is not accepted that cycle.
REQ-033 SHALL continue rendering during CLEAR, so mixed old and cleared cells may display.

Reset
REQ-034 SHALL, on reset, drive game_data=00, game_enable=0, frame_tick=0 and wr_ready=0, and clear the read pipeline.
REQ-035 SHALL, on reset release, enter CLEAR at sweep address 0, so the map reads all-00 after 1200 cycles.
REQ-036 SHALL, when reset is asserted mid-sweep, restart the sweep from address 0.
REQ-037 SHALL not reset the map RAM itself; it is initialised only via the sweep.

Structure
REQ-038 SHALL keep the cell-code constants, GRID_W/GRID_H, display limits 640/480 and the 1200-cell count in shared package snake_pkg.
REQ-039 SHALL use one sub-module grid_ram: a simple dual-port RAM with 1 write and 1 registered read port, 1200x2.

Verification
REQ-040 SHALL verify: reset 1 cycle, release -> clear_busy high for exactly 1200 cycles, wr_ready 0 throughout, and every cell then reads 00.
REQ-041 SHALL verify: in vblank, write col=3 row=2 data=10, then scan X=48..63, Y=32..47 -> game_data=10 two cycles after each such X/Y and 00 elsewhere.
REQ-042 SHALL verify: wr_valid held high with Y=100 -> wr_ready 0 and no commit; at Y=480 -> handshake completes in the first cycle and frame_tick pulses once.
REQ-043 SHALL verify: write col=40 row=0 data=11 in vblank -> accepted, and address 0 / cell (0,1) unchanged.
REQ-044 SHALL verify: clear_req and wr_valid together in vblank -> CLEAR entered, write not accepted, and a second clear_req at sweep address 500 does not restart the sweep.
REQ-045 SHALL verify: X=640 or Y=480 -> game_enable 0 and game_data 00 after 2 cycles, and X=639, Y=479 -> game_enable 1.
